// File: rtl/multicycle_control_unit_pkg.sv
// mcu_pkg: shared types and constants for the multicycle RV32I control unit.
//   - state_t      : FSM states (TRAP only when MCU_ILLEGAL_TRAP_EN is defined)
//   - OP_*         : supported major opcodes
//   - ALU_*        : ALUControl encodings
//   - RES_/SRCA_/SRCB_/IMM_* : datapath mux select values
//   - aluop_t      : coarse ALU request handed to alu_decoder
//   - ctrl_t       : bundle of every combinational control output
// Optional feature macro: MCU_ILLEGAL_TRAP_EN
package mcu_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

`ifdef MCU_ILLEGAL_TRAP_EN
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_TRAP
  } state_t;
`else
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL
  } state_t;
`endif

  typedef struct packed {
    logic       mem_req;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       illegal;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    aluop_t     aluop;
  } ctrl_t;

  function automatic logic opcode_supported(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_R) ||
           (op == OP_I) || (op == OP_BRANCH) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// multicycle_control_unit_if: control bundle between the control unit and
// the shared-memory multicycle datapath.
//   master : the control unit (consumes instruction/zero_flg/mem_ready,
//            drives strobes, selects, ALUControl, instret, illegal)
//   slave  : the datapath / memory side
interface multicycle_control_unit_if #(
  parameter int INSTRET_W = 32,
  parameter int ALUCTRL_W = 3
);
  logic [31:0]          instruction;
  logic                 zero_flg;
  logic                 mem_ready;
  logic                 mem_req;
  logic                 PCWrite;
  logic                 AdrSrc;
  logic                 MemWrite;
  logic                 IRWrite;
  logic [1:0]           ResultSrc;
  logic [1:0]           ALUSrcA;
  logic [1:0]           ALUSrcB;
  logic [1:0]           ImmSrc;
  logic [ALUCTRL_W-1:0] ALUControl;
  logic                 RegWrite;
  logic [INSTRET_W-1:0] instret;
  logic                 illegal;

  modport master (
    input  instruction, zero_flg, mem_ready,
    output mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALUControl, RegWrite, instret, illegal
  );

  modport slave (
    output instruction, zero_flg, mem_ready,
    input  mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALUControl, RegWrite, instret, illegal
  );
endinterface

// File: rtl/multicycle_control_unit_alu_decoder.sv
// alu_decoder: combinational ALU operation decode, shared with the pipelined core.
//   aluop_i    : ADD / SUB / FUNCT request from the main controller
//   funct3_i   : instruction[14:12]
//   funct7b5_i : instruction[30]
//   opb5_i     : instruction[5] (1 = register-register form)
//   alu_ctrl_o : ALUControl encoding (zero-extended to ALUCTRL_W)
module alu_decoder
  import mcu_pkg::*;
#(
  parameter int ALUCTRL_W = 3
) (
  input  aluop_t               aluop_i,
  input  logic [2:0]           funct3_i,
  input  logic                 funct7b5_i,
  input  logic                 opb5_i,
  output logic [ALUCTRL_W-1:0] alu_ctrl_o
);
  logic [2:0] code;

  always_comb begin
    code = ALU_ADD;
    case (aluop_i)
      ALUOP_SUB:   code = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          // Only R-type can subtract; addi's imm[10] sits where funct7[5] is.
          3'b000:  code = (opb5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  code = ALU_SLT;
          3'b110:  code = ALU_OR;
          3'b111:  code = ALU_AND;
          default: code = ALU_ADD;
        endcase
      end
      default:     code = ALU_ADD;
    endcase
  end

  assign alu_ctrl_o = ALUCTRL_W'(code);
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: RV32I multicycle controller. Walks each
// instruction through FETCH/DECODE/EXECUTE/MEM/WB, one state per clock,
// stalling memory states on mem_ready and counting retired instructions.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset (state -> FETCH, instret -> 0)
//   mcu   : multicycle_control_unit_if.master (instruction, zero_flg,
//           mem_ready in; strobes, selects, ALUControl, instret, illegal out)
// Optional feature macro: MCU_ILLEGAL_TRAP_EN -- an unsupported opcode parks
// the FSM in TRAP (illegal held high, all strobes low) until reset.
module multicycle_control_unit
  import mcu_pkg::*;
#(
  parameter int INSTRET_W = 32,
  parameter int ALUCTRL_W = 3
) (
  input logic                       clk,
  input logic                       rst_n,
  multicycle_control_unit_if.master mcu
);
  state_t               state_q, state_d;
  logic [INSTRET_W-1:0] instret_q, instret_d;
  ctrl_t                ctl, ctl_gated;
  logic [6:0]           opcode;
  logic [ALUCTRL_W-1:0] alu_ctrl;
  logic                 unused_instr_bits;

  assign opcode = mcu.instruction[6:0];
  // Instruction fields the control path never inspects.
  assign unused_instr_bits = ^{mcu.instruction[31], mcu.instruction[29:15],
                               mcu.instruction[11:7]};

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mcu.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_I:              state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
`ifdef MCU_ILLEGAL_TRAP_EN
          default:           state_d = S_TRAP;
`else
          default:           state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   state_d = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mcu.mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mcu.mem_ready) state_d = S_FETCH;
      S_EXECR,
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
`ifdef MCU_ILLEGAL_TRAP_EN
      S_TRAP:     state_d = S_TRAP;
`endif
      default:    state_d = S_FETCH;
    endcase
  end

  // Retirement = any return to FETCH except the illegal-opcode bailout
  // from DECODE; FETCH->FETCH is just a fetch stall.
  always_comb begin
    instret_d = instret_q;
    if (state_d == S_FETCH && state_q != S_FETCH && state_q != S_DECODE)
      instret_d = instret_q + INSTRET_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  // Per-state controls; anything not set stays 0 / ADD.
  always_comb begin
    ctl = '0;
    case (state_q)
      S_FETCH: begin
        ctl.mem_req    = 1'b1;
        ctl.adr_src    = 1'b0;
        ctl.alu_src_a  = SRCA_PC;
        ctl.alu_src_b  = SRCB_FOUR;
        ctl.result_src = RES_ALURES;
        ctl.ir_write   = mcu.mem_ready;
        ctl.pc_write   = mcu.mem_ready;
      end
      S_DECODE: begin
        // Branch target precomputed here so BEQ only needs the compare.
        ctl.alu_src_a = SRCA_OLDPC;
        ctl.alu_src_b = SRCB_IMM;
        ctl.imm_src   = IMM_B;
        ctl.illegal   = !opcode_supported(opcode);
      end
      S_MEMADR: begin
        ctl.alu_src_a = SRCA_RS1;
        ctl.alu_src_b = SRCB_IMM;
        ctl.imm_src   = opcode[5] ? IMM_S : IMM_I;
      end
      S_MEMREAD: begin
        ctl.mem_req = 1'b1;
        ctl.adr_src = 1'b1;
      end
      S_MEMWB: begin
        ctl.result_src = RES_DATA;
        ctl.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        ctl.mem_req   = 1'b1;
        ctl.adr_src   = 1'b1;
        ctl.mem_write = 1'b1;
      end
      S_EXECR: begin
        ctl.alu_src_a = SRCA_RS1;
        ctl.alu_src_b = SRCB_RS2;
        ctl.aluop     = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ctl.alu_src_a = SRCA_RS1;
        ctl.alu_src_b = SRCB_IMM;
        ctl.imm_src   = IMM_I;
        ctl.aluop     = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctl.result_src = RES_ALUOUT;
        ctl.reg_write  = 1'b1;
      end
      S_BEQ: begin
        ctl.alu_src_a  = SRCA_RS1;
        ctl.alu_src_b  = SRCB_RS2;
        ctl.aluop      = ALUOP_SUB;
        ctl.result_src = RES_ALUOUT;
        ctl.pc_write   = mcu.zero_flg;
      end
      S_JAL: begin
        // Link value OldPC+4 is computed now; ALUOut (branch target from
        // DECODE) is loaded into PC on this same edge.
        ctl.alu_src_a  = SRCA_OLDPC;
        ctl.alu_src_b  = SRCB_FOUR;
        ctl.result_src = RES_ALUOUT;
        ctl.pc_write   = 1'b1;
      end
`ifdef MCU_ILLEGAL_TRAP_EN
      S_TRAP:   ctl.illegal = 1'b1;
`endif
      default: ;
    endcase
  end

  // Reset forces every output low combinationally, so an assertion mid
  // memory access drops mem_req without waiting for a clock.
  assign ctl_gated = rst_n ? ctl : '0;

  alu_decoder #(.ALUCTRL_W(ALUCTRL_W)) u_alu_dec (
    .aluop_i    (ctl_gated.aluop),
    .funct3_i   (mcu.instruction[14:12]),
    .funct7b5_i (mcu.instruction[30]),
    .opb5_i     (mcu.instruction[5]),
    .alu_ctrl_o (alu_ctrl)
  );

  assign mcu.mem_req    = ctl_gated.mem_req;
  assign mcu.PCWrite    = ctl_gated.pc_write;
  assign mcu.AdrSrc     = ctl_gated.adr_src;
  assign mcu.MemWrite   = ctl_gated.mem_write;
  assign mcu.IRWrite    = ctl_gated.ir_write;
  assign mcu.RegWrite   = ctl_gated.reg_write;
  assign mcu.illegal    = ctl_gated.illegal;
  assign mcu.ResultSrc  = ctl_gated.result_src;
  assign mcu.ALUSrcA    = ctl_gated.alu_src_a;
  assign mcu.ALUSrcB    = ctl_gated.alu_src_b;
  assign mcu.ImmSrc     = ctl_gated.imm_src;
  assign mcu.ALUControl = alu_ctrl;
  assign mcu.instret    = instret_q;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit (INSTRET_W=8 so the
// counter wrap is reachable). Each instruction is expanded by a reference
// model into the cycle-by-cycle control pattern its RV32I class requires;
// only the fields defined for that step are compared.
module tb_multicycle_control_unit;
  localparam int D = -1;  // "don't care" for a select field
  localparam int C_LOAD = 0, C_STORE = 1, C_R = 2, C_I = 3, C_BR = 4, C_JAL = 5, C_ILL = 6;

  typedef struct packed {
    logic        rdy;
    logic [17:0] exp;
    logic [17:0] care;
  } cyc_t;

  logic        clk = 1'b0, rst_n = 1'b1, rdy = 1'b0, zf = 1'b0;
  logic [31:0] instr = 32'h0;
  logic [17:0] obs;
  logic [7:0]  exp_instret = 8'd0, ir_obs;
  int          checks = 0, errors = 0;
  cyc_t        cq[$];
  logic [17:0] obs_q[$];
  logic [6:0]  ops[6] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};

  multicycle_control_unit_if #(.INSTRET_W(8), .ALUCTRL_W(3)) bus ();

  multicycle_control_unit #(.INSTRET_W(8), .ALUCTRL_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .mcu(bus)
  );

  assign bus.instruction = instr;
  assign bus.zero_flg    = zf;
  assign bus.mem_ready   = rdy;
  // [17]mem_req [16]PCWrite [15]AdrSrc [14]MemWrite [13]IRWrite [12]RegWrite
  // [11]illegal [10:9]ResultSrc [8:7]ALUSrcA [6:5]ALUSrcB [4:3]ImmSrc [2:0]ALUControl
  assign obs = {bus.mem_req, bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite,
                bus.RegWrite, bus.illegal, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB,
                bus.ImmSrc, bus.ALUControl};

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int cls(input logic [31:0] ins);
    case (ins[6:0])
      7'b0000011: return C_LOAD;
      7'b0100011: return C_STORE;
      7'b0110011: return C_R;
      7'b0010011: return C_I;
      7'b1100011: return C_BR;
      7'b1101111: return C_JAL;
      default:    return C_ILL;
    endcase
  endfunction

  // ALU operation an R/I arithmetic instruction asks for.
  function automatic int alu_ref(input logic [31:0] ins);
    case (ins[14:12])
      3'b000:  return (ins[5] && ins[30]) ? 1 : 0;  // sub only for R-type
      3'b010:  return 5;
      3'b110:  return 3;
      3'b111:  return 2;
      default: return 0;
    endcase
  endfunction

  function automatic cyc_t cyc(input bit mr, input bit rq, input bit pw, input bit mwr,
                               input bit irw, input bit rw, input bit il, input int ad,
                               input int rs, input int sa, input int sb, input int im,
                               input int al);
    cyc_t c;
    c.rdy = mr;
    c.exp = '0;
    c.care = '0;
    c.exp[17] = rq; c.exp[16] = pw; c.exp[14] = mwr;
    c.exp[13] = irw; c.exp[12] = rw; c.exp[11] = il;
    c.care[17:16] = 2'b11;
    c.care[14:11] = 4'hF;
    if (ad >= 0) begin c.exp[15]   = ad[0];   c.care[15]   = 1'b1;   end
    if (rs >= 0) begin c.exp[10:9] = rs[1:0]; c.care[10:9] = 2'b11;  end
    if (sa >= 0) begin c.exp[8:7]  = sa[1:0]; c.care[8:7]  = 2'b11;  end
    if (sb >= 0) begin c.exp[6:5]  = sb[1:0]; c.care[6:5]  = 2'b11;  end
    if (im >= 0) begin c.exp[4:3]  = im[1:0]; c.care[4:3]  = 2'b11;  end
    if (al >= 0) begin c.exp[2:0]  = al[2:0]; c.care[2:0]  = 3'b111; end
    return c;
  endfunction

  function automatic bit rb();
    return bit'($urandom_range(1, 0));
  endfunction

  // Expand one instruction into its expected cycles, drive it, and record
  // what the DUT showed each cycle plus instret afterwards.
  task automatic run(input logic [31:0] ins, input logic z, input int fw, input int mw);
    int c;
    cq.delete();
    obs_q.delete();
    instr = ins;
    zf = z;
    c = cls(ins);
    repeat (fw) cq.push_back(cyc(0, 1,0,0,0,0,0, 0, 2,0,2,D,0));
    cq.push_back(cyc(1, 1,1,0,1,0,0, 0, 2,0,2,D,0));
    cq.push_back(cyc(rb(), 0,0,0,0,0,(c == C_ILL), D, D,1,1,2,0));
    case (c)
      C_LOAD: begin
        cq.push_back(cyc(rb(), 0,0,0,0,0,0, D, D,2,1,0,0));
        repeat (mw) cq.push_back(cyc(0, 1,0,0,0,0,0, 1, D,D,D,D,D));
        cq.push_back(cyc(1, 1,0,0,0,0,0, 1, D,D,D,D,D));
        cq.push_back(cyc(rb(), 0,0,0,0,1,0, D, 1,D,D,D,D));
      end
      C_STORE: begin
        cq.push_back(cyc(rb(), 0,0,0,0,0,0, D, D,2,1,1,0));
        repeat (mw) cq.push_back(cyc(0, 1,0,1,0,0,0, 1, D,D,D,D,D));
        cq.push_back(cyc(1, 1,0,1,0,0,0, 1, D,D,D,D,D));
      end
      C_R: begin
        cq.push_back(cyc(rb(), 0,0,0,0,0,0, D, D,2,0,D,alu_ref(ins)));
        cq.push_back(cyc(rb(), 0,0,0,0,1,0, D, 0,D,D,D,D));
      end
      C_I: begin
        cq.push_back(cyc(rb(), 0,0,0,0,0,0, D, D,2,1,0,alu_ref(ins)));
        cq.push_back(cyc(rb(), 0,0,0,0,1,0, D, 0,D,D,D,D));
      end
      C_BR: cq.push_back(cyc(rb(), 0,z,0,0,0,0, D, 0,2,0,D,1));
      C_JAL: begin
        cq.push_back(cyc(rb(), 0,1,0,0,0,0, D, 0,1,2,D,0));
        cq.push_back(cyc(rb(), 0,0,0,0,1,0, D, 0,D,D,D,D));
      end
      default: begin
`ifdef MCU_ILLEGAL_TRAP_EN
        repeat (3) cq.push_back(cyc(1, 0,0,0,0,0,1, D, D,D,D,D,D));
`endif
      end
    endcase
    foreach (cq[i]) begin
      @(negedge clk);
      rdy = cq[i].rdy;
      #1;
      obs_q.push_back(obs);
    end
    @(posedge clk);
    #1;
    ir_obs = bus.instret;
    if (c != C_ILL) exp_instret = exp_instret + 8'd1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    rdy = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (obs !== 18'h0) begin errors++; $display("FAIL reset_outputs got %h want 0", obs); end
    checks++;
    if (bus.instret !== 8'd0) begin errors++; $display("FAIL reset_instret got %0d want 0", bus.instret); end
    @(negedge clk);
    rdy = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++;
    if (obs[17] !== 1'b1 || obs[16] !== 1'b0 || obs[13] !== 1'b0) begin
      errors++; $display("FAIL reset_fetch got %h want mem_req=1 PCWrite=0 IRWrite=0", obs);
    end
  endtask

  task automatic test_alu_ops();
    logic [31:0] prog[3] = '{32'h002081B3, 32'h402081B3, 32'hFFF08193};
    foreach (prog[k]) begin
      run(prog[k], 1'b0, 0, 0);
      foreach (cq[i]) begin
        checks++;
        if ((obs_q[i] & cq[i].care) !== (cq[i].exp & cq[i].care)) begin
          errors++;
          $display("FAIL alu_ops instr %h cycle %0d got %h want %h mask %h", prog[k], i, obs_q[i], cq[i].exp, cq[i].care);
        end
      end
      checks++;
      if (ir_obs !== exp_instret) begin errors++; $display("FAIL alu_ops_instret got %0d want %0d", ir_obs, exp_instret); end
    end
  endtask

  task automatic test_mem_stall();
    logic [31:0] prog[2] = '{32'h0000A183, 32'h0020A023};
    foreach (prog[k]) begin
      run(prog[k], 1'b0, 2, 3);
      foreach (cq[i]) begin
        checks++;
        if ((obs_q[i] & cq[i].care) !== (cq[i].exp & cq[i].care)) begin
          errors++;
          $display("FAIL mem_stall instr %h cycle %0d got %h want %h mask %h", prog[k], i, obs_q[i], cq[i].exp, cq[i].care);
        end
      end
      checks++;
      if (ir_obs !== exp_instret) begin errors++; $display("FAIL mem_stall_instret got %0d want %0d", ir_obs, exp_instret); end
    end
  endtask

  task automatic test_branch_jal();
    logic [31:0] prog[3] = '{32'h00208463, 32'h00208463, 32'h0100006F};
    logic        zs[3]   = '{1'b1, 1'b0, 1'b0};
    foreach (prog[k]) begin
      run(prog[k], zs[k], 1, 0);
      foreach (cq[i]) begin
        checks++;
        if ((obs_q[i] & cq[i].care) !== (cq[i].exp & cq[i].care)) begin
          errors++;
          $display("FAIL branch_jal instr %h z=%0d cycle %0d got %h want %h mask %h", prog[k], zs[k], i, obs_q[i], cq[i].exp, cq[i].care);
        end
      end
      checks++;
      if (ir_obs !== exp_instret) begin errors++; $display("FAIL branch_jal_instret got %0d want %0d", ir_obs, exp_instret); end
    end
  endtask

  task automatic test_illegal();
    run(32'h0000007F, 1'b0, 0, 0);
    foreach (cq[i]) begin
      checks++;
      if ((obs_q[i] & cq[i].care) !== (cq[i].exp & cq[i].care)) begin
        errors++; $display("FAIL illegal cycle %0d got %h want %h mask %h", i, obs_q[i], cq[i].exp, cq[i].care);
      end
    end
    checks++;
    if (ir_obs !== exp_instret) begin errors++; $display("FAIL illegal_instret got %0d want %0d", ir_obs, exp_instret); end
`ifdef MCU_ILLEGAL_TRAP_EN
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 18'h0) begin errors++; $display("FAIL trap_reset got %h want 0", obs); end
    @(negedge clk);
    rdy = 1'b0;
    rst_n = 1'b1;
    exp_instret = 8'd0;
`endif
  endtask

  task automatic test_random();
    logic [31:0] r;
    int          k;
`ifdef MCU_ILLEGAL_TRAP_EN
    int          nk = 6;
`else
    int          nk = 7;
`endif
    for (int n = 0; n < 60; n++) begin
      r = $urandom;
      k = $urandom_range(nk - 1, 0);
      if (k < 6) r[6:0] = ops[k];
      else begin
        do r[6:0] = 7'($urandom); while (cls(r) != C_ILL);
      end
      run(r, 1'($urandom), $urandom_range(2, 0), $urandom_range(3, 0));
      foreach (cq[i]) begin
        checks++;
        if ((obs_q[i] & cq[i].care) !== (cq[i].exp & cq[i].care)) begin
          errors++; $display("FAIL random instr %h cycle %0d got %h want %h mask %h", r, i, obs_q[i], cq[i].exp, cq[i].care);
        end
      end
      checks++;
      if (ir_obs !== exp_instret) begin errors++; $display("FAIL random_instret instr %h got %0d want %0d", r, ir_obs, exp_instret); end
    end
  endtask

  task automatic test_reset_midstate();
    instr = 32'h0000A183;
    zf = 1'b0;
    @(negedge clk); rdy = 1'b1;  // FETCH
    @(negedge clk); rdy = 1'b0;  // DECODE
    @(negedge clk);              // MEMADR
    @(negedge clk);              // MEMREAD, waiting on memory
    #1;
    checks++;
    if (obs[17] !== 1'b1 || obs[15] !== 1'b1) begin errors++; $display("FAIL midreset_memread got %h want mem_req=1 AdrSrc=1", obs); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 18'h0) begin errors++; $display("FAIL midreset_outputs got %h want 0", obs); end
    checks++;
    if (bus.instret !== 8'd0) begin errors++; $display("FAIL midreset_instret got %0d want 0", bus.instret); end
    @(negedge clk);
    rst_n = 1'b1;
    exp_instret = 8'd0;
    #1;
    checks++;
    if (obs[17] !== 1'b1 || obs[15] !== 1'b0 || obs[13] !== 1'b0 || obs[6:5] !== 2'b10) begin
      errors++; $display("FAIL midreset_fetch got %h want FETCH pattern", obs);
    end
  endtask

  task automatic test_wrap();
    for (int n = 0; n < 256; n++) begin
      run(32'h002081B3, 1'b0, 0, 0);
      if (n == 0 || n == 255) begin
        foreach (cq[i]) begin
          checks++;
          if ((obs_q[i] & cq[i].care) !== (cq[i].exp & cq[i].care)) begin
            errors++; $display("FAIL wrap n=%0d cycle %0d got %h want %h mask %h", n, i, obs_q[i], cq[i].exp, cq[i].care);
          end
        end
      end
      checks++;
      if (ir_obs !== exp_instret) begin errors++; $display("FAIL wrap_instret n=%0d got %0d want %0d", n, ir_obs, exp_instret); end
    end
    checks++;
    if (bus.instret !== 8'd0) begin errors++; $display("FAIL wrap_final got %0d want 0", bus.instret); end
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_mem_stall();
    test_branch_jal();
    test_illegal();
    test_random();
    test_reset_midstate();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
